// File: rtl/ar_sender_drop.sv
// rtl/ar_sender_drop.sv - AR sender: forwards accepted reads, answers dropped reads with SLVERR bursts
module ar_sender_drop #(
  parameter int AXI_M_ADDR_WIDTH = 40,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int AXI_ID_WIDTH     = 8,
  parameter int AXI_USER_WIDTH   = 6,
  parameter int DROP_FIFO_DEPTH  = 4
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RBI,
  input  logic                        accept_i,
  input  logic                        drop_i,
  input  logic [AXI_M_ADDR_WIDTH-1:0] out_addr_i,
  input  logic                        cache_coherent_i,
  input  logic [AXI_ID_WIDTH-1:0]     id_i,
  input  logic [AXI_USER_WIDTH-1:0]   user_i,
  input  logic [7:0]                  len_i,
  input  logic [2:0]                  size_i,
  input  logic [1:0]                  burst_i,
  input  logic [2:0]                  prot_i,
  output logic                        sent_o,
  output logic [AXI_ID_WIDTH-1:0]     m_arid_o,
  output logic [AXI_M_ADDR_WIDTH-1:0] m_araddr_o,
  output logic [7:0]                  m_arlen_o,
  output logic [2:0]                  m_arsize_o,
  output logic [1:0]                  m_arburst_o,
  output logic [2:0]                  m_arprot_o,
  output logic [3:0]                  m_arcache_o,
  output logic [AXI_USER_WIDTH-1:0]   m_aruser_o,
  output logic                        m_arvalid_o,
  input  logic                        m_arready_i,
  input  logic [AXI_ID_WIDTH-1:0]     m_rid_i,
  input  logic [AXI_DATA_WIDTH-1:0]   m_rdata_i,
  input  logic [1:0]                  m_rresp_i,
  input  logic                        m_rlast_i,
  input  logic [AXI_USER_WIDTH-1:0]   m_ruser_i,
  input  logic                        m_rvalid_i,
  output logic                        m_rready_o,
  output logic [AXI_ID_WIDTH-1:0]     s_rid_o,
  output logic [AXI_DATA_WIDTH-1:0]   s_rdata_o,
  output logic [1:0]                  s_rresp_o,
  output logic                        s_rlast_o,
  output logic [AXI_USER_WIDTH-1:0]   s_ruser_o,
  output logic                        s_rvalid_o,
  input  logic                        s_rready_i
);

  localparam int PW = $clog2(DROP_FIFO_DEPTH);
  localparam logic [PW:0] FIFO_FULL_CNT = (PW+1)'(DROP_FIFO_DEPTH);

  typedef enum logic [1:0] {AR_IDLE, AR_FWD, AR_GUARD} ar_state_t;
  typedef enum logic {ERR_IDLE, ERR_BURST} err_state_t;

  ar_state_t  ar_state;
  err_state_t err_state;

  logic [AXI_ID_WIDTH-1:0]   fifo_id   [DROP_FIFO_DEPTH];
  logic [7:0]                fifo_len  [DROP_FIFO_DEPTH];
  logic [AXI_USER_WIDTH-1:0] fifo_user [DROP_FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [PW:0]               fifo_cnt;
  logic [7:0]                beat_cnt;
  logic                      in_burst;
  logic                      do_push, do_pop, fifo_full;

  assign fifo_full = (fifo_cnt == FIFO_FULL_CNT);
  assign do_pop    = (err_state == ERR_BURST) && s_rready_i && (beat_cnt == 8'd0);
  // A full FIFO still takes a drop when the head burst retires in the same cycle.
  assign do_push   = (ar_state == AR_IDLE) && !accept_i && drop_i && (!fifo_full || do_pop);
  assign sent_o    = do_push || (m_arvalid_o && m_arready_i);

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      ar_state    <= AR_IDLE;
      m_arvalid_o <= 1'b0;
      m_arid_o    <= '0;
      m_araddr_o  <= '0;
      m_arlen_o   <= '0;
      m_arsize_o  <= '0;
      m_arburst_o <= '0;
      m_arprot_o  <= '0;
      m_arcache_o <= '0;
      m_aruser_o  <= '0;
    end else begin
      case (ar_state)
        AR_IDLE: begin
          if (accept_i) begin
            ar_state    <= AR_FWD;
            m_arvalid_o <= 1'b1;
            m_arid_o    <= id_i;
            m_araddr_o  <= out_addr_i;
            m_arlen_o   <= len_i;
            m_arsize_o  <= size_i;
            m_arburst_o <= burst_i;
            m_arprot_o  <= prot_i;
            m_arcache_o <= cache_coherent_i ? 4'b1111 : 4'b0000;
            m_aruser_o  <= user_i;
          end else if (do_push) begin
            ar_state <= AR_GUARD;
          end
        end
        AR_FWD: begin
          if (m_arready_i) begin
            ar_state    <= AR_GUARD;
            m_arvalid_o <= 1'b0;
          end
        end
        default: ar_state <= AR_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (do_push) begin
      fifo_id[wr_ptr]   <= id_i;
      fifo_len[wr_ptr]  <= len_i;
      fifo_user[wr_ptr] <= user_i;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Error bursts start only between master bursts and never while a master beat is pending.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      err_state <= ERR_IDLE;
      beat_cnt  <= 8'd0;
      in_burst  <= 1'b0;
    end else begin
      if (m_rvalid_i && m_rready_o) in_burst <= !m_rlast_i;
      case (err_state)
        ERR_IDLE: begin
          if ((fifo_cnt != '0) && !in_burst && !m_rvalid_i) begin
            err_state <= ERR_BURST;
            beat_cnt  <= fifo_len[rd_ptr];
          end
        end
        default: begin
          if (s_rready_i) begin
            if (beat_cnt == 8'd0) err_state <= ERR_IDLE;
            else                  beat_cnt  <= beat_cnt - 8'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    s_rvalid_o = m_rvalid_i;
    s_rid_o    = m_rid_i;
    s_rdata_o  = m_rdata_i;
    s_rresp_o  = m_rresp_i;
    s_rlast_o  = m_rlast_i;
    s_ruser_o  = m_ruser_i;
    m_rready_o = s_rready_i;
    if (err_state == ERR_BURST) begin
      s_rvalid_o = 1'b1;
      s_rid_o    = fifo_id[rd_ptr];
      s_rdata_o  = '0;
      s_rresp_o  = 2'b10;
      s_rlast_o  = (beat_cnt == 8'd0);
      s_ruser_o  = fifo_user[rd_ptr];
      m_rready_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_ar_sender_drop.sv
// tb/tb_ar_sender_drop.sv - scoreboard bench for ar_sender_drop
module tb_ar_sender_drop;

  logic        Clk_CI = 1'b0;
  logic        Rst_RBI = 1'b0;
  logic        accept_i, drop_i, cache_coherent_i;
  logic [39:0] out_addr_i;
  logic [7:0]  id_i, len_i;
  logic [5:0]  user_i;
  logic [2:0]  size_i, prot_i;
  logic [1:0]  burst_i;
  logic        sent_o;
  logic [7:0]  m_arid_o, m_arlen_o;
  logic [39:0] m_araddr_o;
  logic [2:0]  m_arsize_o, m_arprot_o;
  logic [1:0]  m_arburst_o;
  logic [3:0]  m_arcache_o;
  logic [5:0]  m_aruser_o;
  logic        m_arvalid_o, m_arready_i;
  logic [7:0]  m_rid_i;
  logic [63:0] m_rdata_i;
  logic [1:0]  m_rresp_i;
  logic        m_rlast_i, m_rvalid_i, m_rready_o;
  logic [5:0]  m_ruser_i;
  logic [7:0]  s_rid_o;
  logic [63:0] s_rdata_o;
  logic [1:0]  s_rresp_o;
  logic        s_rlast_o, s_rvalid_o, s_rready_i;
  logic [5:0]  s_ruser_o;

  always #5 Clk_CI = ~Clk_CI;

  ar_sender_drop dut (
    .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI), .accept_i(accept_i), .drop_i(drop_i),
    .out_addr_i(out_addr_i), .cache_coherent_i(cache_coherent_i), .id_i(id_i), .user_i(user_i),
    .len_i(len_i), .size_i(size_i), .burst_i(burst_i), .prot_i(prot_i), .sent_o(sent_o),
    .m_arid_o(m_arid_o), .m_araddr_o(m_araddr_o), .m_arlen_o(m_arlen_o), .m_arsize_o(m_arsize_o),
    .m_arburst_o(m_arburst_o), .m_arprot_o(m_arprot_o), .m_arcache_o(m_arcache_o),
    .m_aruser_o(m_aruser_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rlast_i(m_rlast_i),
    .m_ruser_i(m_ruser_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
    .s_rid_o(s_rid_o), .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rlast_o(s_rlast_o),
    .s_ruser_o(s_ruser_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i)
  );

  typedef struct {
    logic [39:0] addr;
    logic [7:0]  id;
    logic [7:0]  len;
    logic [3:0]  cache;
  } ar_t;

  typedef struct {
    logic [7:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [5:0]  user;
  } rbeat_t;

  ar_t    ar_q[$];
  rbeat_t r_q[$];
  ar_t    ar_e;
  rbeat_t r_e;
  int checks = 0, errors = 0, sent_count = 0, ar_count = 0, r_count = 0;
  logic        prev_stall = 1'b0;
  logic [39:0] prev_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT completes an AR or slave R handshake.
  always @(negedge Clk_CI) begin
    if (Rst_RBI) begin
      if (sent_o) sent_count++;
      if (prev_stall) begin
        chk("ar_valid_held", 64'(m_arvalid_o), 64'd1);
        chk("ar_addr_held", 64'(m_araddr_o), 64'(prev_addr));
      end
      if (m_arvalid_o && !m_arready_i) chk("sent_before_hs", 64'(sent_o), 64'd0);
      prev_stall = m_arvalid_o && !m_arready_i;
      prev_addr  = m_araddr_o;
      if (m_arvalid_o && m_arready_i) begin
        ar_count++;
        chk("sent_at_hs", 64'(sent_o), 64'd1);
        chk("ar_expected_avail", 64'(ar_q.size() != 0), 64'd1);
        if (ar_q.size() != 0) begin
          ar_e = ar_q.pop_front();
          chk("ar_addr", 64'(m_araddr_o), 64'(ar_e.addr));
          chk("ar_id", 64'(m_arid_o), 64'(ar_e.id));
          chk("ar_len", 64'(m_arlen_o), 64'(ar_e.len));
          chk("ar_cache", 64'(m_arcache_o), 64'(ar_e.cache));
        end
      end
      if (s_rvalid_o && s_rready_i) begin
        r_count++;
        chk("r_expected_avail", 64'(r_q.size() != 0), 64'd1);
        if (r_q.size() != 0) begin
          r_e = r_q.pop_front();
          chk("r_id", 64'(s_rid_o), 64'(r_e.id));
          chk("r_data", s_rdata_o, r_e.data);
          chk("r_resp", 64'(s_rresp_o), 64'(r_e.resp));
          chk("r_last", 64'(s_rlast_o), 64'(r_e.last));
          chk("r_user", 64'(s_ruser_o), 64'(r_e.user));
        end
        if (s_rresp_o == 2'b10) chk("m_rready_in_err", 64'(m_rready_o), 64'd0);
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge Clk_CI);
    #1;
  endtask

  task automatic push_err(input logic [7:0] id, input logic [7:0] len, input logic [5:0] user);
    rbeat_t b;
    for (int i = 0; i <= int'(len); i++) begin
      b.id = id; b.data = '0; b.resp = 2'b10; b.last = (i == int'(len)); b.user = user;
      r_q.push_back(b);
    end
  endtask

  task automatic wait_sent(input string name, input int bound);
    int n;
    n = 0;
    @(negedge Clk_CI);
    while (!sent_o && n < bound) begin
      @(negedge Clk_CI);
      n++;
    end
    chk(name, 64'(sent_o), 64'd1);
  endtask

  task automatic do_accept(input logic [39:0] addr, input logic [7:0] id, input logic [7:0] len,
                           input logic coh);
    ar_t a;
    a.addr = addr; a.id = id; a.len = len; a.cache = coh ? 4'hF : 4'h0;
    ar_q.push_back(a);
    out_addr_i = addr; id_i = id; len_i = len; cache_coherent_i = coh;
    size_i = 3'd3; burst_i = 2'd1; prot_i = 3'd2; user_i = 6'h0A;
    accept_i = 1'b1;
    wait_sent("accept_sent_timeout", 50);
    tick();
    accept_i = 1'b0;
  endtask

  task automatic do_drop(input logic [7:0] id, input logic [7:0] len, input logic [5:0] user,
                         input bit push_exp, input int bound);
    if (push_exp) push_err(id, len, user);
    id_i = id; len_i = len; user_i = user;
    drop_i = 1'b1;
    wait_sent("drop_sent_timeout", bound);
    tick();
    drop_i = 1'b0;
  endtask

  task automatic m_beat(input logic [7:0] id, input logic [63:0] data, input logic last);
    int n;
    m_rid_i = id; m_rdata_i = data; m_rresp_i = 2'b00; m_rlast_i = last; m_ruser_i = 6'h01;
    m_rvalid_i = 1'b1;
    n = 0;
    @(negedge Clk_CI);
    while (!m_rready_o && n < 50) begin
      @(negedge Clk_CI);
      n++;
    end
    chk("m_beat_ready_timeout", 64'(m_rready_o), 64'd1);
    tick();
    m_rvalid_i = 1'b0;
    tick();
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n;
    n = 0;
    while (r_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk(name, 64'(r_q.size()), 64'd0);
  endtask

  initial begin
    rbeat_t b;
    accept_i = 0; drop_i = 0; cache_coherent_i = 0; out_addr_i = '0; id_i = '0; len_i = '0;
    user_i = '0; size_i = '0; prot_i = '0; burst_i = '0; m_arready_i = 0;
    m_rid_i = '0; m_rdata_i = '0; m_rresp_i = '0; m_rlast_i = 0; m_rvalid_i = 0; m_ruser_i = '0;
    s_rready_i = 0;
    repeat (3) @(posedge Clk_CI);
    @(negedge Clk_CI);
    chk("rst_arvalid", 64'(m_arvalid_o), 64'd0);
    chk("rst_sent", 64'(sent_o), 64'd0);
    chk("rst_s_rvalid", 64'(s_rvalid_o), 64'd0);
    chk("rst_m_rready", 64'(m_rready_o), 64'd0);
    chk("rst_araddr", 64'(m_araddr_o), 64'd0);
    chk("rst_s_rdata", s_rdata_o, 64'd0);
    tick();
    Rst_RBI = 1'b1;
    tick();

    // Accept with ready high: valid one cycle after accept, sent on the handshake.
    m_arready_i = 1'b1;
    ar_e.addr = 40'h12_3456_7000; ar_e.id = 8'h11; ar_e.len = 8'h07; ar_e.cache = 4'h0;
    ar_q.push_back(ar_e);
    out_addr_i = 40'h12_3456_7000; id_i = 8'h11; len_i = 8'h07; cache_coherent_i = 1'b0;
    size_i = 3'd3; burst_i = 2'd1; prot_i = 3'd0;
    accept_i = 1'b1;
    @(negedge Clk_CI);
    chk("t1_arvalid_N", 64'(m_arvalid_o), 64'd0);
    chk("t1_sent_N", 64'(sent_o), 64'd0);
    @(negedge Clk_CI);
    chk("t1_arvalid_N1", 64'(m_arvalid_o), 64'd1);
    chk("t1_sent_N1", 64'(sent_o), 64'd1);
    tick();
    accept_i = 1'b0;
    repeat (4) tick();
    chk("t1_ar_count", 64'(ar_count), 64'd1);
    chk("t1_sent_count", 64'(sent_count), 64'd1);

    // Accept with ready held low for several cycles.
    m_arready_i = 1'b0;
    fork
      do_accept(40'h00_ABCD_E000, 8'h22, 8'h0F, 1'b1);
      begin
        repeat (6) tick();
        m_arready_i = 1'b1;
      end
    join
    repeat (3) tick();
    chk("t2_ar_count", 64'(ar_count), 64'd2);
    chk("t2_sent_count", 64'(sent_count), 64'd2);

    // Single drop, len 3: four SLVERR beats, last on the fourth.
    s_rready_i = 1'b1;
    do_drop(8'h2A, 8'd3, 6'h15, 1'b1, 20);
    wait_drain("t3_drain", 100);
    chk("t3_r_count", 64'(r_count), 64'd4);
    chk("t3_sent_count", 64'(sent_count), 64'd3);

    // Five drops into a depth-4 FIFO with the slave stalled.
    s_rready_i = 1'b0;
    do_drop(8'h40, 8'd1, 6'h00, 1'b1, 20);
    do_drop(8'h41, 8'd0, 6'h01, 1'b1, 20);
    do_drop(8'h42, 8'd2, 6'h02, 1'b1, 20);
    do_drop(8'h43, 8'd1, 6'h03, 1'b1, 20);
    push_err(8'h44, 8'd0, 6'h04);
    id_i = 8'h44; len_i = 8'd0; user_i = 6'h04;
    drop_i = 1'b1;
    repeat (10) tick();
    chk("t4_stall_sent_count", 64'(sent_count), 64'd7);
    s_rready_i = 1'b1;
    wait_sent("t4_fifth_sent_timeout", 100);
    tick();
    drop_i = 1'b0;
    wait_drain("t4_drain", 200);
    chk("t4_r_count", 64'(r_count), 64'd13);
    chk("t4_sent_count", 64'(sent_count), 64'd8);

    // Drop queued while an 8-beat master burst is in flight.
    for (int i = 0; i < 8; i++) begin
      b.id = 8'h55; b.data = 64'(i) * 64'h0101_0101_0101_0101; b.resp = 2'b00;
      b.last = (i == 7); b.user = 6'h01;
      r_q.push_back(b);
    end
    push_err(8'h3C, 8'd3, 6'h02);
    m_beat(8'h55, 64'h0, 1'b0);
    do_drop(8'h3C, 8'd3, 6'h02, 1'b0, 20);
    for (int i = 1; i < 8; i++) m_beat(8'h55, 64'(i) * 64'h0101_0101_0101_0101, i == 7);
    wait_drain("t5_drain", 100);
    chk("t5_r_count", 64'(r_count), 64'd25);
    chk("t5_sent_count", 64'(sent_count), 64'd9);

    // Reset on beat 2 of a 4-beat error burst.
    s_rready_i = 1'b0;
    do_drop(8'h77, 8'd3, 6'h03, 1'b0, 20);
    b.id = 8'h77; b.data = '0; b.resp = 2'b10; b.last = 1'b0; b.user = 6'h03;
    r_q.push_back(b);
    repeat (2) tick();
    s_rready_i = 1'b1;
    tick();
    s_rready_i = 1'b0;
    #2;
    Rst_RBI = 1'b0;
    #1;
    chk("t6_rvalid_in_reset", 64'(s_rvalid_o), 64'd0);
    chk("t6_arvalid_in_reset", 64'(m_arvalid_o), 64'd0);
    s_rready_i = 1'b1;
    tick();
    Rst_RBI = 1'b1;
    repeat (20) tick();
    chk("t6_r_count", 64'(r_count), 64'd26);
    chk("t6_r_queue_empty", 64'(r_q.size()), 64'd0);
    chk("t6_sent_count", 64'(sent_count), 64'd10);
    chk("final_ar_queue_empty", 64'(ar_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
